mul_add_seq: RTL and testbench

- Sequential shift-and-add multiply-accumulate unit for the calculator datapath.
- Computes P = A*B + C, the inverse of the array divider: quotient × divisor + remainder rebuilds the dividend.
- Also supports plain multiply (C ignored).
- Sits beside the divider on the same 6-bit operand / 4-bit divisor buses. Uses a start/busy/done handshake so the calculator controller can sequence it.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/mul_add_step.sv | 29 ++
 rtl/mul_add_seq.sv | 101 ++++++++++
 tb/tb_mul_add_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared widths and state encoding for the calculator datapath
//               multiply-accumulate unit (mul_add_seq).
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Operand A / addend C width (quotient / remainder bus)
    localparam int A_W   = 6;
    // Operand B width (divisor / multiplier); also the iteration count
    localparam int B_W   = 4;
    // Full product width; the result can never wrap at this width
    localparam int P_W   = A_W + B_W;
    // Iteration counter width
    localparam int CNT_W = $clog2(B_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/mul_add_step.sv
`default_nettype none
// ============================================================================
// Module      : mul_add_step
// Description : One shift-and-add iteration: adds the multiplicand, shifted
//               by the current bit position, when the multiplier bit is set.
//               Kept separate so the loop can be unrolled into array form.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_add_step
    import calc_pkg::*;
(
    input  logic [P_W-1:0]   i_acc,
    input  logic [A_W-1:0]   i_a_reg,
    input  logic             i_b_bit,
    input  logic [CNT_W-1:0] i_cnt,
    output logic [P_W-1:0]   o_acc
);

    logic [P_W-1:0] w_shifted;

    // Partial product for this bit position; widened before shifting so no
    // bits of the multiplicand are lost.
    assign w_shifted = P_W'(i_a_reg) << i_cnt;

    // Accumulate only when the current multiplier bit is set.
    assign o_acc = i_b_bit ? (i_acc + w_shifted) : i_acc;

endmodule : mul_add_step
`default_nettype wire

// File: rtl/mul_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_add_seq
// Description : Sequential shift-and-add multiply-accumulate, P = A*B + C
//               (or P = A*B when control=1). Fixed latency of B_W iteration
//               cycles with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_add_seq
    import calc_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           control,
    input  logic [A_W-1:0] A,
    input  logic [B_W-1:0] B,
    input  logic [A_W-1:0] C,
    output logic           busy,
    output logic           done,
    output logic [P_W-1:0] P,
    output logic [A_W-1:0] S,
    output logic           ovf
);

    state_t           r_state;
    logic [A_W-1:0]   r_a;
    logic [B_W-1:0]   r_b;
    logic [P_W-1:0]   r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [P_W-1:0]   r_p;
    logic             r_busy;
    logic             r_done;
    logic [P_W-1:0]   w_next_acc;

    // Combinational iteration stage
    mul_add_step u_step (
        .i_acc   (r_acc),
        .i_a_reg (r_a),
        .i_b_bit (r_b[0]),
        .i_cnt   (r_cnt),
        .o_acc   (w_next_acc)
    );

    // Control FSM, iteration counter and registered outputs. The addend (or
    // zero in multiply-only mode) is folded into the accumulator at
    // acceptance, so control does not need to be kept afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_acc   <= control ? '0 : P_W'(C);
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc <= w_next_acc;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(B_W - 1)) begin
                        r_p     <= w_next_acc;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign P    = r_p;
    // Low part and overflow flag follow the held result directly.
    assign S    = r_p[A_W-1:0];
    assign ovf  = |r_p[P_W-1:A_W];

endmodule : mul_add_seq
`default_nettype wire

// File: tb/tb_mul_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_add_seq
// Description : Scoreboard testbench for mul_add_seq with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_add_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       control;
    logic [5:0] A;
    logic [3:0] B;
    logic [5:0] C;
    logic       busy;
    logic       done;
    logic [9:0] P;
    logic [5:0] S;
    logic       ovf;

    typedef struct {
        int p;
        int s;
        int o;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   done_seen = 0;

    mul_add_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .control (control),
        .A       (A),
        .B       (B),
        .C       (C),
        .busy    (busy),
        .done    (done),
        .P       (P),
        .S       (S),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: pops the expected result whenever the DUT signals done
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got P=%0d expected no done", P);
            end else begin
                e = exp_q.pop_front();
                chk("P", int'(P), e.p);
                chk("S", int'(S), e.s);
                chk("ovf", int'(ovf), e.o);
            end
        end
    end

    // Present one start pulse; returns at the negedge after the accept edge
    task automatic issue(input logic ctl, input int a, input int b, input int c);
        start   = 1'b1;
        control = ctl;
        A       = 6'(a);
        B       = 4'(b);
        C       = 6'(c);
        @(negedge clk);
        start   = 1'b0;
        A       = 6'h3f;
        B       = 4'hf;
        C       = 6'h3f;
        control = ~ctl;
    endtask

    task automatic push(input int p, input int s, input int o);
        exp_t e;
        e.p = p;
        e.s = s;
        e.o = o;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for done, counting busy cycles on the way
    task automatic wait_done(output int busy_cycles);
        int  i;
        bit  got;
        busy_cycles = 0;
        got = 0;
        for (i = 0; i < 20; i++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
    endtask

    initial begin
        int bc;
        int d0;
        rst     = 1'b1;
        start   = 1'b0;
        control = 1'b0;
        A       = '0;
        B       = '0;
        C       = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_P", int'(P), 0);
        chk("rst_S", int'(S), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst = 1'b0;
        @(negedge clk);

        // Quotient/remainder rebuild: 5*3+2
        push(17, 17, 0);
        issue(1'b0, 5, 3, 2);
        wait_done(bc);
        chk("busy_cycles", bc, 4);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("hold_P", int'(P), 17);

        // Maximum: 63*15+63 = 1008
        push(1008, 48, 1);
        issue(1'b0, 63, 15, 63);
        wait_done(bc);
        chk("busy_cycles_max", bc, 4);
        @(negedge clk);

        // Multiply only: 7*9, C ignored
        push(63, 63, 0);
        issue(1'b1, 7, 9, 33);
        wait_done(bc);
        @(negedge clk);

        // Zero multiplier with an ignored start while busy
        push(5, 5, 0);
        d0 = done_seen;
        issue(1'b0, 42, 0, 5);
        start = 1'b1;
        A     = 6'd1;
        B     = 4'd1;
        C     = 6'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);
        repeat (8) @(negedge clk);
        chk("single_done", done_seen - d0, 1);
        chk("idle_after_zero", int'(busy), 0);

        // Back-to-back: 7*9+33 = 96, then start in the DONE cycle
        push(96, 32, 1);
        issue(1'b0, 7, 9, 33);
        wait_done(bc);
        push(5, 5, 0);
        issue(1'b0, 2, 2, 1);
        chk("b2b_done_drop", int'(done), 0);
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_hold_P", int'(P), 96);
        @(negedge clk);
        chk("b2b_hold_P2", int'(P), 96);
        wait_done(bc);
        @(negedge clk);

        // Reset in the 2nd RUN cycle abandons the operation
        d0 = done_seen;
        issue(1'b0, 10, 10, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_P", int'(P), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_seen - d0, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mul_add_seq
`default_nettype wire
